// File: rtl/pc_fetch_unit.sv
// Instruction fetch front end: one outstanding word request, a registered output
// slot backed by a one-entry skid buffer, and flush/drain handling on redirect.
//
// state | meaning
// IDLE  | no request; either waiting to hand the skid entry on, or about to request
// REQ   | fetching the word at pc
// DRAIN | finishing a request abandoned by a redirect; its data is dropped
module pc_fetch_unit #(
  parameter int                AWIDTH    = 15,
  parameter int                DWIDTH    = 32,
  parameter logic [AWIDTH-1:0] RESET_PC  = '0,
  parameter logic [DWIDTH-1:0] NOP_INSTR = '0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              stall,
  input  logic              redirect,
  input  logic [AWIDTH-1:0] redirect_addr,
  output logic              imem_req,
  output logic [AWIDTH-1:0] imem_addr,
  input  logic              imem_ack,
  input  logic [DWIDTH-1:0] imem_rdata,
  output logic              fetch_valid,
  output logic [AWIDTH-1:0] fetch_addr,
  output logic [DWIDTH-1:0] fetch_instr
);

  typedef enum logic [1:0] {IDLE, REQ, DRAIN} state_t;

  state_t              state, state_nxt;
  logic [AWIDTH-1:0]   pc, pc_nxt;
  logic                fetch_valid_nxt;
  logic [AWIDTH-1:0]   fetch_addr_nxt;
  logic [DWIDTH-1:0]   fetch_instr_nxt;
  logic                skid_valid, skid_valid_nxt;
  logic [AWIDTH-1:0]   skid_addr, skid_addr_nxt;
  logic [DWIDTH-1:0]   skid_instr, skid_instr_nxt;
  logic [AWIDTH-1:0]   drain_addr, drain_addr_nxt;
  logic                consume;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      pc          <= RESET_PC;
      fetch_valid <= 1'b0;
      fetch_addr  <= '0;
      fetch_instr <= NOP_INSTR;
      skid_valid  <= 1'b0;
      skid_addr   <= '0;
      skid_instr  <= '0;
      drain_addr  <= '0;
    end else begin
      state       <= state_nxt;
      pc          <= pc_nxt;
      fetch_valid <= fetch_valid_nxt;
      fetch_addr  <= fetch_addr_nxt;
      fetch_instr <= fetch_instr_nxt;
      skid_valid  <= skid_valid_nxt;
      skid_addr   <= skid_addr_nxt;
      skid_instr  <= skid_instr_nxt;
      drain_addr  <= drain_addr_nxt;
    end
  end

  always_comb begin
    state_nxt       = state;
    pc_nxt          = pc;
    fetch_valid_nxt = fetch_valid;
    fetch_addr_nxt  = fetch_addr;
    fetch_instr_nxt = fetch_instr;
    skid_valid_nxt  = skid_valid;
    skid_addr_nxt   = skid_addr;
    skid_instr_nxt  = skid_instr;
    drain_addr_nxt  = drain_addr;

    consume = fetch_valid && !stall;

    // A consumed slot empties unless a load below refills it on the same edge.
    if (consume) begin
      fetch_valid_nxt = 1'b0;
      fetch_instr_nxt = NOP_INSTR;
    end

    if (redirect) begin
      pc_nxt          = redirect_addr;
      fetch_valid_nxt = 1'b0;
      fetch_instr_nxt = NOP_INSTR;
      skid_valid_nxt  = 1'b0;
    end

    unique case (state)
      IDLE: begin
        if (redirect) begin
          state_nxt = REQ;
        end else if (skid_valid) begin
          if (consume || !fetch_valid) begin
            fetch_valid_nxt = 1'b1;
            fetch_addr_nxt  = skid_addr;
            fetch_instr_nxt = skid_instr;
            skid_valid_nxt  = 1'b0;
            state_nxt       = REQ;
          end
        end else begin
          state_nxt = REQ;
        end
      end

      REQ: begin
        if (redirect) begin
          // An unacked request must still complete on the bus before moving on.
          if (imem_ack) begin
            state_nxt = REQ;
          end else begin
            drain_addr_nxt = pc;
            state_nxt      = DRAIN;
          end
        end else if (imem_ack) begin
          pc_nxt = pc + AWIDTH'(1);
          if (!fetch_valid || consume) begin
            fetch_valid_nxt = 1'b1;
            fetch_addr_nxt  = pc;
            fetch_instr_nxt = imem_rdata;
            state_nxt       = REQ;
          end else begin
            skid_valid_nxt = 1'b1;
            skid_addr_nxt  = pc;
            skid_instr_nxt = imem_rdata;
            state_nxt      = IDLE;
          end
        end
      end

      DRAIN: begin
        if (imem_ack) state_nxt = REQ;
      end

      default: state_nxt = IDLE;
    endcase
  end

  assign imem_req  = (state == REQ) || (state == DRAIN);
  assign imem_addr = (state == DRAIN) ? drain_addr : pc;

endmodule
